// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer commit sequencer.
// The entry struct is used both for storage and for decoding the head entry.
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int IX_W      = $clog2(ROB_DEPTH);
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;

  typedef logic [IX_W-1:0]  rob_ix_t;
  typedef logic [IX_W:0]    rob_cnt_t;
  typedef logic [REG_W-1:0] reg_addr_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    reg_addr_t       rd;
    logic            wr_rd;
    logic            branch;
    logic            mispredict;
    logic [XLEN-1:0] data;
  } rob_entry_t;

  // Pointers wrap naturally because ROB_DEPTH is a power of two.
  function automatic rob_ix_t ix_inc(input rob_ix_t ix);
    return ix + rob_ix_t'(1);
  endfunction

endpackage

// File: rtl/rob_commit_ctrl.sv
// In-order commit sequencer: allocates ROB slots, captures CDB results and
// retires the head into the register file, or flushes on a mispredicted branch.
module rob_commit_ctrl
  import rob_pkg::*;
(
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             alloc_in,
  input  logic [REG_W-1:0]                 alloc_rd_in,
  input  logic                             alloc_wr_rd_in,
  input  logic                             alloc_branch_in,
  output logic                             alloc_ready_out,
  output logic [IX_W-1:0]                  alloc_ix_out,
  input  logic                             cdb_valid_in,
  input  logic [IX_W-1:0]                  cdb_ix_in,
  input  logic [XLEN-1:0]                  cdb_data_in,
  input  logic                             cdb_mispredict_in,
  output logic                             rf_we_out,
  output logic [REG_W-1:0]                 rf_wa_out,
  output logic [XLEN-1:0]                  rf_wd_out,
  output logic [IX_W-1:0]                  rf_wrob_ix_out,
  output logic                             flush_out,
  output logic [ROB_DEPTH-1:0][REG_W-1:0]  flush_addrs_out,
  output logic [IX_W:0]                    count_out
);

  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t rob_d [ROB_DEPTH];
  rob_ix_t    head_q, head_d;
  rob_ix_t    tail_q, tail_d;
  rob_cnt_t   count_q, count_d;

  logic                            rf_we_q;
  reg_addr_t                       rf_wa_q;
  logic [XLEN-1:0]                 rf_wd_q;
  rob_ix_t                         rf_wrob_ix_q;
  logic                            flush_q;
  logic [ROB_DEPTH-1:0][REG_W-1:0] flush_addrs_q;
  logic [ROB_DEPTH-1:0][REG_W-1:0] flush_addrs_d;

  rob_entry_t head_ent;
  logic       flush_pend;
  logic       commit;
  logic       alloc_ready;
  logic       alloc_acc;
  rob_ix_t    pack_ix;
  rob_ix_t    pack_k;

  always_comb begin
    head_ent    = rob_q[head_q];
    flush_pend  = head_ent.valid & head_ent.ready & head_ent.branch & head_ent.mispredict;
    commit      = head_ent.valid & head_ent.ready & ~flush_pend;
    alloc_ready = (count_q < rob_cnt_t'(ROB_DEPTH)) && !flush_pend;
    alloc_acc   = alloc_in & alloc_ready;
  end

  // Younger writers are packed densely, oldest first, starting after the branch.
  always_comb begin
    flush_addrs_d = '0;
    pack_k        = '0;
    pack_ix       = '0;
    for (int i = 1; i < ROB_DEPTH; i++) begin
      pack_ix = head_q + rob_ix_t'(i);
      if (rob_q[pack_ix].valid && rob_q[pack_ix].wr_rd) begin
        flush_addrs_d[pack_k] = rob_q[pack_ix].rd;
        pack_k                = pack_k + rob_ix_t'(1);
      end
    end
  end

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_pend) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_d[i].valid = 1'b0;
      end
      head_d  = ix_inc(head_q);
      tail_d  = ix_inc(head_q);
      count_d = '0;
    end else begin
      if (cdb_valid_in && rob_q[cdb_ix_in].valid) begin
        rob_d[cdb_ix_in].ready      = 1'b1;
        rob_d[cdb_ix_in].data       = cdb_data_in;
        rob_d[cdb_ix_in].mispredict = cdb_mispredict_in;
      end
      if (commit) begin
        rob_d[head_q].valid = 1'b0;
        head_d              = ix_inc(head_q);
      end
      // Full is judged on the registered count, so a same-edge commit never frees the tail.
      if (alloc_acc) begin
        rob_d[tail_q].valid      = 1'b1;
        rob_d[tail_q].ready      = 1'b0;
        rob_d[tail_q].rd         = alloc_rd_in;
        rob_d[tail_q].wr_rd      = alloc_wr_rd_in;
        rob_d[tail_q].branch     = alloc_branch_in;
        rob_d[tail_q].mispredict = 1'b0;
        rob_d[tail_q].data       = '0;
        tail_d                   = ix_inc(tail_q);
      end
      if (alloc_acc && !commit) begin
        count_d = count_q + rob_cnt_t'(1);
      end else if (!alloc_acc && commit) begin
        count_d = count_q - rob_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Retire and flush buses are single-cycle pulses; data fields read zero when idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rf_we_q       <= 1'b0;
      rf_wa_q       <= '0;
      rf_wd_q       <= '0;
      rf_wrob_ix_q  <= '0;
      flush_q       <= 1'b0;
      flush_addrs_q <= '0;
    end else begin
      rf_we_q       <= commit & head_ent.wr_rd;
      rf_wa_q       <= commit ? head_ent.rd : '0;
      rf_wd_q       <= commit ? head_ent.data : '0;
      rf_wrob_ix_q  <= commit ? head_q : '0;
      flush_q       <= flush_pend;
      flush_addrs_q <= flush_pend ? flush_addrs_d : '0;
    end
  end

  assign alloc_ready_out = alloc_ready;
  assign alloc_ix_out    = tail_q;
  assign count_out       = count_q;
  assign rf_we_out       = rf_we_q;
  assign rf_wa_out       = rf_wa_q;
  assign rf_wd_out       = rf_wd_q;
  assign rf_wrob_ix_out  = rf_wrob_ix_q;
  assign flush_out       = flush_q;
  assign flush_addrs_out = flush_addrs_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: a queue-based reference model checked
// every cycle, a table-driven mispredict sequence, directed corner cases and random traffic.
module tb_rob_commit_ctrl;
  import rob_pkg::*;

  logic                            clk_in;
  logic                            rst_in;
  logic                            alloc_in;
  logic [4:0]                      alloc_rd_in;
  logic                            alloc_wr_rd_in;
  logic                            alloc_branch_in;
  logic                            alloc_ready_out;
  logic [2:0]                      alloc_ix_out;
  logic                            cdb_valid_in;
  logic [2:0]                      cdb_ix_in;
  logic [31:0]                     cdb_data_in;
  logic                            cdb_mispredict_in;
  logic                            rf_we_out;
  logic [4:0]                      rf_wa_out;
  logic [31:0]                     rf_wd_out;
  logic [2:0]                      rf_wrob_ix_out;
  logic                            flush_out;
  logic [7:0][4:0]                 flush_addrs_out;
  logic [3:0]                      count_out;

  int checks = 0;
  int errors = 0;

  rob_commit_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .alloc_in(alloc_in), .alloc_rd_in(alloc_rd_in), .alloc_wr_rd_in(alloc_wr_rd_in),
    .alloc_branch_in(alloc_branch_in), .alloc_ready_out(alloc_ready_out), .alloc_ix_out(alloc_ix_out),
    .cdb_valid_in(cdb_valid_in), .cdb_ix_in(cdb_ix_in), .cdb_data_in(cdb_data_in),
    .cdb_mispredict_in(cdb_mispredict_in),
    .rf_we_out(rf_we_out), .rf_wa_out(rf_wa_out), .rf_wd_out(rf_wd_out), .rf_wrob_ix_out(rf_wrob_ix_out),
    .flush_out(flush_out), .flush_addrs_out(flush_addrs_out), .count_out(count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          rst;
    bit          alloc;
    logic [4:0]  rd;
    bit          wr;
    bit          br;
    bit          cdbV;
    logic [2:0]  cdbIx;
    logic [31:0] data;
    bit          mis;
  } stim_t;

  typedef struct {
    stim_t      s;
    bit         expReady;
    int         expIx;
    int         expCount;
    bit         expWe;
    bit         expFlush;
    int         expA0;
    int         expA1;
    int         expA2;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    bit          wr;
    bit          br;
    bit          mis;
    bit          rdy;
    logic [31:0] data;
    int          ix;
  } mEnt_t;

  // Reference model: the ROB is just an ordered queue of in-flight instructions.
  mEnt_t      mq[$];
  int         mHead = 0;
  bit         mWe = 0;
  logic [4:0] mWa = '0;
  logic [31:0] mWd = '0;
  int         mWix = 0;
  bit         mFlush = 0;
  int         mAddrs[8];

  function automatic bit mFlushPend();
    return mq.size() > 0 && mq[0].rdy && mq[0].br && mq[0].mis;
  endfunction

  function automatic bit mAllocReady();
    return mq.size() < 8 && !mFlushPend();
  endfunction

  function automatic int mTail();
    return (mHead + mq.size()) % 8;
  endfunction

  task automatic modelStep(input stim_t s);
    bit fp, ar, cm;
    int tail, k;
    mEnt_t e;
    mWe = 0;
    mFlush = 0;
    for (int j = 0; j < 8; j++) mAddrs[j] = 0;
    if (s.rst) begin
      mq.delete();
      mHead = 0;
      return;
    end
    fp = mFlushPend();
    ar = mAllocReady();
    tail = mTail();
    if (fp) begin
      mFlush = 1;
      k = 0;
      for (int j = 1; j < mq.size(); j++) begin
        if (mq[j].wr) begin
          mAddrs[k] = int'(mq[j].rd);
          k++;
        end
      end
      mq.delete();
      mHead = (mHead + 1) % 8;
      return;
    end
    cm = mq.size() > 0 && mq[0].rdy;
    if (cm) begin
      mWe = mq[0].wr;
      mWa = mq[0].rd;
      mWd = mq[0].data;
      mWix = mq[0].ix;
    end
    if (s.cdbV) begin
      for (int j = 0; j < mq.size(); j++) begin
        if (mq[j].ix == int'(s.cdbIx)) begin
          mq[j].rdy = 1;
          mq[j].data = s.data;
          mq[j].mis = s.mis;
        end
      end
    end
    if (cm) begin
      void'(mq.pop_front());
      mHead = (mHead + 1) % 8;
    end
    if (s.alloc && ar) begin
      e.rd = s.rd; e.wr = s.wr; e.br = s.br; e.mis = 0; e.rdy = 0; e.data = '0; e.ix = tail;
      mq.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t sIdle();
    stim_t s;
    s.rst = 0; s.alloc = 0; s.rd = '0; s.wr = 0; s.br = 0;
    s.cdbV = 0; s.cdbIx = '0; s.data = '0; s.mis = 0;
    return s;
  endfunction

  function automatic stim_t sRst();
    stim_t s = sIdle();
    s.rst = 1;
    return s;
  endfunction

  function automatic stim_t sAlloc(input int rd, input bit wr, input bit br);
    stim_t s = sIdle();
    s.alloc = 1; s.rd = 5'(rd); s.wr = wr; s.br = br;
    return s;
  endfunction

  function automatic stim_t sCdb(input stim_t base, input int ix, input logic [31:0] d, input bit mis);
    stim_t s = base;
    s.cdbV = 1; s.cdbIx = 3'(ix); s.data = d; s.mis = mis;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input bit rdy, input int ix, input int cnt,
                                 input bit we, input bit fl, input int a0, input int a1, input int a2);
    vec_t v;
    v.s = s; v.expReady = rdy; v.expIx = ix; v.expCount = cnt;
    v.expWe = we; v.expFlush = fl; v.expA0 = a0; v.expA1 = a1; v.expA2 = a2;
    return v;
  endfunction

  // One clock: drive at the negedge, check combinational status, clock, check registered outputs.
  task automatic applyStimulus(input stim_t s);
    rst_in = s.rst; alloc_in = s.alloc; alloc_rd_in = s.rd; alloc_wr_rd_in = s.wr;
    alloc_branch_in = s.br; cdb_valid_in = s.cdbV; cdb_ix_in = s.cdbIx;
    cdb_data_in = s.data; cdb_mispredict_in = s.mis;
    #1;
    if (!s.rst) begin
      checkOutput("alloc_ready", 64'(alloc_ready_out), 64'(mAllocReady()));
      checkOutput("alloc_ix", 64'(alloc_ix_out), 64'(mTail()));
    end
    @(posedge clk_in);
    modelStep(s);
    @(negedge clk_in);
    checkOutput("count", 64'(count_out), 64'(mq.size()));
    checkOutput("rf_we", 64'(rf_we_out), 64'(mWe));
    checkOutput("flush", 64'(flush_out), 64'(mFlush));
    if (mWe) begin
      checkOutput("rf_wa", 64'(rf_wa_out), 64'(mWa));
      checkOutput("rf_wd", 64'(rf_wd_out), 64'(mWd));
      checkOutput("rf_wrob_ix", 64'(rf_wrob_ix_out), 64'(mWix));
    end
    if (mFlush) begin
      for (int j = 0; j < 8; j++)
        checkOutput($sformatf("flush_addr%0d", j), 64'(flush_addrs_out[j]), 64'(mAddrs[j]));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  vec_t t3[7];
  int   wrapIx[4];

  initial begin
    stim_t s;
    int r;
    rst_in = 1; alloc_in = 0; alloc_rd_in = '0; alloc_wr_rd_in = 0; alloc_branch_in = 0;
    cdb_valid_in = 0; cdb_ix_in = '0; cdb_data_in = '0; cdb_mispredict_in = 0;

    t3[0] = mkVec(sAlloc(0, 0, 1),  1, 1, 1, 0, 0, 0, 0, 0);
    t3[1] = mkVec(sAlloc(5, 1, 0),  1, 2, 2, 0, 0, 0, 0, 0);
    t3[2] = mkVec(sAlloc(3, 0, 0),  1, 3, 3, 0, 0, 0, 0, 0);
    t3[3] = mkVec(sAlloc(9, 1, 0),  1, 4, 4, 0, 0, 0, 0, 0);
    t3[4] = mkVec(sCdb(sIdle(), 0, 32'h0, 1), 0, 4, 4, 0, 0, 0, 0, 0);
    t3[5] = mkVec(sAlloc(7, 1, 0),  1, 1, 0, 0, 1, 5, 9, 0);
    t3[6] = mkVec(sAlloc(11, 1, 0), 1, 2, 1, 0, 0, 0, 0, 0);
    wrapIx = '{6, 7, 0, 1};

    // Reset state
    applyStimulus(sRst());
    checkOutput("reset_count", 64'(count_out), 64'd0);
    checkOutput("reset_ready", 64'(alloc_ready_out), 64'd1);
    checkOutput("reset_ix", 64'(alloc_ix_out), 64'd0);
    checkOutput("reset_we", 64'(rf_we_out), 64'd0);
    checkOutput("reset_flush", 64'(flush_out), 64'd0);

    // T1 fill / drain
    for (int i = 0; i < 8; i++) applyStimulus(sAlloc(i + 1, 1, 0));
    checkOutput("t1_full_ready", 64'(alloc_ready_out), 64'd0);
    checkOutput("t1_full_count", 64'(count_out), 64'd8);
    for (int i = 7; i >= 0; i--) applyStimulus(sCdb(sIdle(), i, 32'h100 + 32'(i), 0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(sIdle());
      checkOutput("t1_we", 64'(rf_we_out), 64'd1);
      checkOutput("t1_wa", 64'(rf_wa_out), 64'(i + 1));
      checkOutput("t1_wrob", 64'(rf_wrob_ix_out), 64'(i));
      checkOutput("t1_wd", 64'(rf_wd_out), 64'(32'h100 + 32'(i)));
    end
    checkOutput("t1_empty", 64'(count_out), 64'd0);

    // T2 wrap
    applyStimulus(sRst());
    for (int i = 0; i < 6; i++) applyStimulus(sAlloc(10 + i, 1, 0));
    for (int i = 0; i < 6; i++) applyStimulus(sCdb(sIdle(), i, 32'h200 + 32'(i), 0));
    for (int i = 0; i < 3; i++) applyStimulus(sIdle());
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_alloc_ix", 64'(alloc_ix_out), 64'(wrapIx[i]));
      applyStimulus(sAlloc(20 + i, 1, 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(sCdb(sIdle(), wrapIx[i], 32'h300 + 32'(i), 0));
    for (int i = 0; i < 3; i++) applyStimulus(sIdle());

    // T3 mispredict (table-driven)
    applyStimulus(sRst());
    for (int i = 0; i < 7; i++) begin
      applyStimulus(t3[i].s);
      checkOutput($sformatf("t3_ready%0d", i), 64'(alloc_ready_out), 64'(t3[i].expReady));
      checkOutput($sformatf("t3_ix%0d", i), 64'(alloc_ix_out), 64'(t3[i].expIx));
      checkOutput($sformatf("t3_count%0d", i), 64'(count_out), 64'(t3[i].expCount));
      checkOutput($sformatf("t3_we%0d", i), 64'(rf_we_out), 64'(t3[i].expWe));
      checkOutput($sformatf("t3_flush%0d", i), 64'(flush_out), 64'(t3[i].expFlush));
      if (t3[i].expFlush) begin
        checkOutput("t3_addr0", 64'(flush_addrs_out[0]), 64'(t3[i].expA0));
        checkOutput("t3_addr1", 64'(flush_addrs_out[1]), 64'(t3[i].expA1));
        checkOutput("t3_addr2", 64'(flush_addrs_out[2]), 64'(t3[i].expA2));
      end
    end

    // T4 same-cycle commit and alloc
    applyStimulus(sRst());
    for (int i = 0; i < 8; i++) applyStimulus(sAlloc(i + 1, 1, 0));
    applyStimulus(sCdb(sAlloc(30, 1, 0), 0, 32'hA0, 0));
    applyStimulus(sCdb(sAlloc(31, 1, 0), 1, 32'hA1, 0));
    checkOutput("t4_rejected_count", 64'(count_out), 64'd7);
    applyStimulus(sAlloc(20, 1, 0));
    checkOutput("t4_balanced_count", 64'(count_out), 64'd7);
    checkOutput("t4_tail", 64'(alloc_ix_out), 64'd1);

    // T5 CDB to head, CDB to invalid index
    applyStimulus(sRst());
    applyStimulus(sAlloc(3, 1, 0));
    applyStimulus(sAlloc(4, 1, 0));
    applyStimulus(sCdb(sIdle(), 0, 32'h55, 0));
    checkOutput("t5_we_n1", 64'(rf_we_out), 64'd0);
    applyStimulus(sIdle());
    checkOutput("t5_we_n2", 64'(rf_we_out), 64'd1);
    checkOutput("t5_wa_n2", 64'(rf_wa_out), 64'd3);
    applyStimulus(sCdb(sIdle(), 5, 32'h77, 0));
    checkOutput("t5_inv_count", 64'(count_out), 64'd1);
    checkOutput("t5_inv_ix", 64'(alloc_ix_out), 64'd2);
    checkOutput("t5_inv_we", 64'(rf_we_out), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(sAlloc(12 + i, 1, 0));
    for (int i = 1; i < 5; i++) applyStimulus(sCdb(sIdle(), i, 32'h400 + 32'(i), 0));
    for (int i = 0; i < 4; i++) applyStimulus(sIdle());
    checkOutput("t5_stale_ready", 64'(count_out), 64'd1);

    // T6 reset with live entries and a pending flush
    applyStimulus(sRst());
    applyStimulus(sAlloc(0, 0, 1));
    for (int i = 0; i < 4; i++) applyStimulus(sAlloc(6 + i, 1, 0));
    applyStimulus(sCdb(sIdle(), 0, 32'h0, 1));
    checkOutput("t6_pending", 64'(alloc_ready_out), 64'd0);
    s = sRst();
    s.alloc = 1;
    applyStimulus(s);
    checkOutput("t6_count", 64'(count_out), 64'd0);
    checkOutput("t6_flush", 64'(flush_out), 64'd0);
    checkOutput("t6_we", 64'(rf_we_out), 64'd0);
    checkOutput("t6_ix", 64'(alloc_ix_out), 64'd0);
    applyStimulus(sIdle());
    checkOutput("t6_flush_after", 64'(flush_out), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      s = sIdle();
      r = int'($urandom_range(99, 0));
      s.rst   = (r < 2);
      s.alloc = ($urandom_range(99, 0) < 60);
      s.rd    = 5'($urandom_range(31, 0));
      s.wr    = ($urandom_range(3, 0) != 0);
      s.br    = ($urandom_range(5, 0) == 0);
      s.cdbV  = ($urandom_range(1, 0) == 1);
      s.cdbIx = 3'($urandom_range(7, 0));
      s.data  = $urandom;
      s.mis   = ($urandom_range(2, 0) == 0);
      applyStimulus(s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
